// File: rtl/memoria_pkg.sv
// Shared constants for the MEM-stage data memory: access widths and dump FSM encoding.
package memoria_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'b00,
    DUMP_LOAD = 2'b01,
    DUMP_SEND = 2'b10,
    DUMP_DONE = 2'b11
  } dump_state_e;

endpackage

// File: rtl/byte_lane_align.sv
// Byte-lane steering for a little-endian 32-bit word: alignment fault, load extract/extend,
// and store merge of the addressed lanes into the current word.
module byte_lane_align
  import memoria_pkg::*;
(
  input  logic [1:0]  lane_i,
  input  logic [1:0]  width_i,
  input  logic        unsigned_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic        step_i,
  input  logic [31:0] word_i,
  input  logic [31:0] store_i,
  output logic        misaligned_o,
  output logic        write_en_o,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic        is_byte;
  logic        is_half;
  logic        access;
  logic [3:0]  be;
  logic [31:0] shifted;
  logic [31:0] st_rep;

  assign is_byte = (width_i == WIDTH_BYTE);
  assign is_half = (width_i == WIDTH_HALF);
  assign access  = (read_i | write_i) & step_i;

  // Reserved width 2'b11 falls through to word handling everywhere below.
  assign misaligned_o = access & ((is_half & lane_i[0]) |
                                  (!is_byte & !is_half & (lane_i != 2'b00)));
  assign write_en_o   = write_i & step_i & !misaligned_o;
  assign shifted      = word_i >> {lane_i, 3'b000};

  always_comb begin
    load_o = '0;
    if (read_i && step_i && !misaligned_o) begin
      if (is_byte)      load_o = {{24{!unsigned_i & shifted[7]}}, shifted[7:0]};
      else if (is_half) load_o = {{16{!unsigned_i & shifted[15]}}, shifted[15:0]};
      else              load_o = word_i;
    end
  end

  always_comb begin
    be     = 4'b0000;
    st_rep = store_i;
    if (is_byte) begin
      be[lane_i] = 1'b1;
      st_rep     = {4{store_i[7:0]}};
    end else if (is_half) begin
      be     = lane_i[1] ? 4'b1100 : 4'b0011;
      st_rep = {2{store_i[15:0]}};
    end else begin
      be = 4'b1111;
    end
  end

  always_comb begin
    merged_o = word_i;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged_o[8*i +: 8] = st_rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/memoria_datos_sized.sv
// MEM-stage data memory: byte/half/word RAM, registered debug read port and a
// valid/ready engine that streams every word out to the debug unit.
//
// state | meaning
// IDLE  | waiting for i_DumpStart
// LOAD  | snapshot memory[ptr] into the output registers
// SEND  | o_DumpValid held until the consumer takes the word
// DONE  | one-cycle o_DumpDone pulse
module memoria_datos_sized
  import memoria_pkg::*;
#(
  parameter  int NBITS  = 32,
  parameter  int CELDAS = 64,
  localparam int AW     = $clog2(CELDAS)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NBITS-1:0] i_ALUDireccion,
  input  logic [NBITS-1:0] i_DatoRegistro,
  input  logic             i_MemWrite,
  input  logic             i_MemRead,
  input  logic [1:0]       i_Width,
  input  logic             i_Unsigned,
  input  logic             i_Step,
  output logic [NBITS-1:0] o_DatoLeido,
  output logic             o_Misaligned,
  input  logic [AW-1:0]    i_DebugDireccion,
  output logic [NBITS-1:0] o_DebugDato,
  input  logic             i_DumpStart,
  input  logic             i_DumpReady,
  output logic             o_DumpValid,
  output logic [AW-1:0]    o_DumpAddr,
  output logic [NBITS-1:0] o_DumpData,
  output logic             o_DumpBusy,
  output logic             o_DumpDone
);

  localparam logic [AW-1:0] LAST_IDX = AW'(CELDAS - 1);

  logic [NBITS-1:0] mem_q [CELDAS];
  logic [AW-1:0]    widx;
  logic [NBITS-1:0] merged_d;
  logic             we;
  logic             unused_addr_hi;

  logic [NBITS-1:0] debug_q;
  dump_state_e      state_q;
  logic [AW-1:0]    ptr_q;
  logic             valid_q;
  logic [AW-1:0]    addr_q;
  logic [NBITS-1:0] data_q;
  logic             done_q;

  // Upper address bits are ignored: the word index wraps modulo CELDAS.
  assign widx           = i_ALUDireccion[AW+1:2];
  assign unused_addr_hi = ^i_ALUDireccion[NBITS-1:AW+2];

  byte_lane_align u_align (
    .lane_i      (i_ALUDireccion[1:0]),
    .width_i     (i_Width),
    .unsigned_i  (i_Unsigned),
    .read_i      (i_MemRead),
    .write_i     (i_MemWrite),
    .step_i      (i_Step),
    .word_i      (mem_q[widx]),
    .store_i     (i_DatoRegistro),
    .misaligned_o(o_Misaligned),
    .write_en_o  (we),
    .load_o      (o_DatoLeido),
    .merged_o    (merged_d)
  );

  always_ff @(posedge i_clk) begin
    if (we) mem_q[widx] <= merged_d;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) debug_q <= '0;
    else         debug_q <= mem_q[i_DebugDireccion];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= DUMP_IDLE;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        DUMP_IDLE: begin
          done_q <= 1'b0;
          if (i_DumpStart) begin
            ptr_q   <= '0;
            state_q <= DUMP_LOAD;
          end
        end
        DUMP_LOAD: begin
          data_q  <= mem_q[ptr_q];
          addr_q  <= ptr_q;
          valid_q <= 1'b1;
          state_q <= DUMP_SEND;
        end
        DUMP_SEND: begin
          if (i_DumpReady) begin
            valid_q <= 1'b0;
            if (ptr_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= DUMP_DONE;
            end else begin
              ptr_q   <= ptr_q + AW'(1);
              state_q <= DUMP_LOAD;
            end
          end
        end
        DUMP_DONE: begin
          done_q  <= 1'b0;
          state_q <= DUMP_IDLE;
        end
        default: state_q <= DUMP_IDLE;
      endcase
    end
  end

  assign o_DebugDato = debug_q;
  assign o_DumpValid = valid_q;
  assign o_DumpAddr  = addr_q;
  assign o_DumpData  = data_q;
  assign o_DumpDone  = done_q;
  assign o_DumpBusy  = (state_q != DUMP_IDLE);

endmodule

// File: tb/tb_memoria_datos_sized.sv
// Directed bench for memoria_datos_sized (CELDAS=16): lane access, faults, debug port, dump engine.
module tb_memoria_datos_sized;
  import memoria_pkg::*;

  localparam int NBITS  = 32;
  localparam int CELDAS = 16;
  localparam int AW     = 4;

  logic             clk;
  logic             rst;
  logic [NBITS-1:0] addr;
  logic [NBITS-1:0] wdata;
  logic             mem_write;
  logic             mem_read;
  logic [1:0]       width;
  logic             uns;
  logic             step;
  logic [NBITS-1:0] dato;
  logic             mis;
  logic [AW-1:0]    dbg_addr;
  logic [NBITS-1:0] dbg_dato;
  logic             dump_start;
  logic             ready;
  logic             dump_valid;
  logic [AW-1:0]    dump_addr;
  logic [NBITS-1:0] dump_data;
  logic             dump_busy;
  logic             dump_done;

  int errors = 0;
  int checks = 0;

  memoria_datos_sized #(.NBITS(NBITS), .CELDAS(CELDAS)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_ALUDireccion  (addr),
    .i_DatoRegistro  (wdata),
    .i_MemWrite      (mem_write),
    .i_MemRead       (mem_read),
    .i_Width         (width),
    .i_Unsigned      (uns),
    .i_Step          (step),
    .o_DatoLeido     (dato),
    .o_Misaligned    (mis),
    .i_DebugDireccion(dbg_addr),
    .o_DebugDato     (dbg_dato),
    .i_DumpStart     (dump_start),
    .i_DumpReady     (ready),
    .o_DumpValid     (dump_valid),
    .o_DumpAddr      (dump_addr),
    .o_DumpData      (dump_data),
    .o_DumpBusy      (dump_busy),
    .o_DumpDone      (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    addr = a; wdata = d; width = w; step = 1'b1; mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] a, input logic [1:0] w,
                          input logic u, input logic s, input logic [31:0] exp_d,
                          input logic exp_m);
    addr = a; width = w; uns = u; step = s; mem_read = 1'b1;
    #1;
    chk(tag, dato, exp_d);
    chk({tag, "_mis"}, 32'(mis), 32'(exp_m));
    mem_read = 1'b0; step = 1'b1;
  endtask

  task automatic init_mem();
    for (int i = 0; i < CELDAS; i++) store(32'(i * 4), 32'(i), WIDTH_WORD);
  endtask

  int          beats;
  int          done_cnt;
  logic        held;
  logic [31:0] held_addr;
  logic [31:0] held_data;

  initial begin
    rst = 1'b0; addr = '0; wdata = '0; mem_write = 1'b0; mem_read = 1'b0;
    width = WIDTH_WORD; uns = 1'b0; step = 1'b1; dbg_addr = '0;
    dump_start = 1'b0; ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_debug", dbg_dato, 32'h0);
    chk("rst_valid", 32'(dump_valid), 32'h0);
    chk("rst_addr", 32'(dump_addr), 32'h0);
    chk("rst_data", dump_data, 32'h0);
    chk("rst_busy", 32'(dump_busy), 32'h0);
    chk("rst_done", 32'(dump_done), 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    init_mem();

    // lane extraction on a known word
    store(32'h8, 32'hDEADBEEF, WIDTH_WORD);
    load_chk("lb_8",   32'h8, WIDTH_BYTE, 1'b0, 1'b1, 32'hFFFFFFEF, 1'b0);
    load_chk("lbu_b",  32'hB, WIDTH_BYTE, 1'b1, 1'b1, 32'h000000DE, 1'b0);
    load_chk("lh_a",   32'hA, WIDTH_HALF, 1'b0, 1'b1, 32'hFFFFDEAD, 1'b0);
    load_chk("lhu_8",  32'h8, WIDTH_HALF, 1'b1, 1'b1, 32'h0000BEEF, 1'b0);
    load_chk("lw_rsv", 32'h8, 2'b11,      1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    load_chk("lw_wrap", 32'h48, WIDTH_WORD, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);

    // partial stores merge only the addressed lanes
    store(32'h5, 32'h12345655, WIDTH_BYTE);
    load_chk("lw_sb", 32'h4, WIDTH_WORD, 1'b0, 1'b1, 32'h00005501, 1'b0);
    store(32'h6, 32'h0000BEEF, WIDTH_HALF);
    load_chk("lw_sh", 32'h4, WIDTH_WORD, 1'b0, 1'b1, 32'hBEEF5501, 1'b0);

    // misaligned store is flagged and dropped
    addr = 32'h3; wdata = 32'hFFFFFFFF; width = WIDTH_HALF; step = 1'b1; mem_write = 1'b1;
    #1;
    chk("sh_3_mis", 32'(mis), 32'h1);
    tick();
    mem_write = 1'b0;
    load_chk("lw_0_after_sh3", 32'h0, WIDTH_WORD, 1'b0, 1'b1, 32'h0, 1'b0);
    load_chk("lw_6", 32'h6, WIDTH_WORD, 1'b0, 1'b1, 32'h0, 1'b1);
    load_chk("lw_6_nostep", 32'h6, WIDTH_WORD, 1'b0, 1'b0, 32'h0, 1'b0);

    // store with pipeline stalled must not write
    addr = 32'hC; wdata = 32'hFFFFFFFF; width = WIDTH_WORD; step = 1'b0; mem_write = 1'b1;
    tick();
    mem_write = 1'b0; step = 1'b1;
    load_chk("lw_c_nostep", 32'hC, WIDTH_WORD, 1'b0, 1'b1, 32'h3, 1'b0);

    // debug port: old data on the store edge, new data one cycle later
    dbg_addr = 4'd3;
    tick();
    chk("dbg_pre", dbg_dato, 32'h3);
    store(32'hC, 32'h0000ABCD, WIDTH_WORD);
    chk("dbg_same_cycle", dbg_dato, 32'h3);
    tick();
    chk("dbg_next_cycle", dbg_dato, 32'h0000ABCD);

    // full dump with ready toggling every cycle
    init_mem();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    chk("busy_after_start", 32'(dump_busy), 32'h1);
    beats = 0; done_cnt = 0; held = 1'b0; held_addr = '0; held_data = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      ready = cyc[0];
      if (held && dump_valid) begin
        chk("stall_addr", 32'(dump_addr), held_addr);
        chk("stall_data", dump_data, held_data);
      end
      held = 1'b0;
      if (dump_valid && ready) begin
        chk("beat_addr", 32'(dump_addr), 32'(beats));
        chk("beat_data", dump_data, 32'(beats));
        beats++;
      end else if (dump_valid) begin
        held = 1'b1; held_addr = 32'(dump_addr); held_data = dump_data;
      end
      if (dump_done) done_cnt++;
      if (done_cnt > 0 && !dump_busy) break;
      tick();
    end
    chk("dump_beats", 32'(beats), 32'd16);
    chk("dump_done_count", 32'(done_cnt), 32'd1);
    chk("idle_after_dump", 32'(dump_busy), 32'h0);

    // reset in the middle of a dump, then restart from word 0
    ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (dump_valid && dump_addr == 4'd5) break;
      tick();
    end
    chk("reached_beat5", 32'(dump_addr), 32'd5);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(dump_valid), 32'h0);
    chk("midrst_busy", 32'(dump_busy), 32'h0);
    chk("midrst_done", 32'(dump_done), 32'h0);
    chk("midrst_debug", dbg_dato, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'(dump_busy), 32'h0);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    tick();
    chk("restart_valid", 32'(dump_valid), 32'h1);
    chk("restart_addr", 32'(dump_addr), 32'h0);
    chk("restart_data", dump_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
